// File: rtl/fetch_if.sv
// Handshake and memory-side signals between the fetch stage, the PC register,
// instruction memory and decode.
interface fetch_if;
    logic [31:0] pc;
    logic        pc_enable;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_fault;
    logic        fetch_err;

    modport master (
        input  pc, flush, mem_rdata, mem_rvalid, instr_ready,
        output pc_enable, mem_req, mem_addr, instr, instr_pc,
               instr_valid, instr_fault, fetch_err
    );

    modport slave (
        output pc, flush, mem_rdata, mem_rvalid, instr_ready,
        input  pc_enable, mem_req, mem_addr, instr, instr_pc,
               instr_valid, instr_fault, fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding read, valid/ready delivery to decode,
// flush/redirect with stale-response drain, misaligned-PC fault, timeout watchdog.
//
// state | meaning
// REQ   | issue read for pc (or fault a misaligned pc)
// WAIT  | read outstanding, waiting for mem_rvalid
// HOLD  | instruction presented to decode until accepted or flushed
// DRAIN | read abandoned by flush, discarding its late response
module fetch_unit #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic    clk,
    input  logic    reset_n,
    fetch_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        err_q, err_d;
    logic        aligned;
    logic        mem_req_c;
    logic        timed_out;

    always_comb begin
        aligned    = (bus.pc[1:0] == 2'b00);
        mem_req_c  = (state_q == S_REQ) && !bus.flush && aligned;
        timed_out  = (cnt_q >= CNT_LAST);
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        err_d      = err_q;

        case (state_q)
            S_REQ: begin
                if (mem_req_c) begin
                    state_d    = S_WAIT;
                    cnt_d      = 8'd0;
                    req_addr_d = bus.pc;
                end else if (!bus.flush) begin
                    state_d    = S_HOLD;
                    instr_d    = NOP_INSTR;
                    instr_pc_d = bus.pc;
                    fault_d    = 1'b1;
                    valid_d    = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.flush) begin
                    // the counter keeps running so DRAIN shares one budget per request
                    state_d = bus.mem_rvalid ? S_REQ : S_DRAIN;
                    cnt_d   = cnt_q + 8'd1;
                end else if (bus.mem_rvalid) begin
                    state_d    = S_HOLD;
                    instr_d    = bus.mem_rdata;
                    instr_pc_d = req_addr_q;
                    fault_d    = 1'b0;
                    valid_d    = 1'b1;
                end else if (timed_out) begin
                    state_d = S_REQ;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) begin
                    state_d = S_REQ;
                end else if (timed_out) begin
                    state_d = S_REQ;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (bus.flush || bus.instr_ready) begin
                    state_d = S_REQ;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_REQ;
            cnt_q      <= 8'd0;
            req_addr_q <= 32'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            err_q      <= err_d;
        end
    end

    assign bus.mem_req     = mem_req_c;
    assign bus.mem_addr    = bus.pc;
    assign bus.pc_enable   = (state_q == S_HOLD) && bus.instr_ready && !bus.flush;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_fault = fault_q;
    assign bus.fetch_err   = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by a randomized run scored against a PC-sequence
// reference model with a queue of expected deliveries.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    fetch_if bus();

    fetch_unit #(.TIMEOUT(4), .NOP_INSTR(NOP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   handshakes = 0;
    bit   rand_phase = 1'b0;
    exp_t exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.fault = (p[1:0] != 2'b00);
        e.instr = e.fault ? NOP : mem_word(p);
        return e;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] p);
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      return p + 32'd4;
        else if (r < 8) return $urandom & 32'h0000_FFFC;
        else            return (p + 32'd4) | 32'($urandom_range(1, 3));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Environment: PC register model plus a randomized-latency instruction memory.
    initial begin : driver
        logic [31:0] cur_pc, pend_addr;
        bit          pending, s_req, s_pcen, s_flush;
        logic [31:0] s_addr;
        int          lat;
        wait (rand_phase);
        cur_pc  = 32'h1000;
        pending = 1'b0;
        lat     = 0;
        exp_q.delete();
        exp_q.push_back(mk_exp(cur_pc));
        while (rand_phase) begin
            @(negedge clk);
            s_req   = bus.mem_req;
            s_addr  = bus.mem_addr;
            s_pcen  = bus.pc_enable;
            s_flush = bus.flush;
            if (s_req) begin
                check("req_addr", s_addr, cur_pc);
                check("single_outstanding", 32'(pending), 32'd0);
            end
            @(posedge clk);
            #1;
            if (s_req) begin
                pending   = 1'b1;
                pend_addr = s_addr;
                lat       = $urandom_range(1, 4);
            end
            if (s_flush) begin
                cur_pc = ($urandom_range(0, 3) == 0) ? (($urandom & 32'hFFFC) | 32'd2)
                                                     : ($urandom & 32'h0000_FFFC);
                exp_q.delete();
                exp_q.push_back(mk_exp(cur_pc));
            end else if (s_pcen) begin
                cur_pc = next_pc(cur_pc);
                exp_q.push_back(mk_exp(cur_pc));
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (pending) begin
                lat--;
                if (lat == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(pend_addr);
                    pending        = 1'b0;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                bus.mem_rvalid = 1'b1;
            end
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.instr_ready = ($urandom_range(0, 9) < 6);
            bus.pc          = cur_pc;
        end
    end

    initial begin : monitor
        bit   hs;
        exp_t e;
        wait (rand_phase);
        forever begin
            @(negedge clk);
            if (!rand_phase) break;
            hs = bus.instr_valid && bus.instr_ready && !bus.flush;
            check("pc_enable_vs_handshake", 32'(bus.pc_enable), 32'(hs));
            check("fetch_err_quiet", 32'(bus.fetch_err), 32'd0);
            if (hs) begin
                handshakes++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL delivery: got instr %h pc %h with nothing expected",
                             bus.instr, bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.instr !== e.instr || bus.instr_pc !== e.pc || bus.instr_fault !== e.fault) begin
                        fails++;
                        $display("FAIL delivery: got instr %h pc %h fault %b expected instr %h pc %h fault %b",
                                 bus.instr, bus.instr_pc, bus.instr_fault, e.instr, e.pc, e.fault);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        reset_n         = 1'b0;
        bus.pc          = 32'h1000;
        bus.flush       = 1'b0;
        bus.mem_rdata   = 32'd0;
        bus.mem_rvalid  = 1'b0;
        bus.instr_ready = 1'b0;

        mid();
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_fault", 32'(bus.instr_fault), 32'd0);
        check("rst_err", 32'(bus.fetch_err), 32'd0);
        check("rst_pc_enable", 32'(bus.pc_enable), 32'd0);

        // basic fetch
        next_cyc(); reset_n = 1'b1;
        mid();
        check("basic_req", 32'(bus.mem_req), 32'd1);
        check("basic_addr", bus.mem_addr, 32'h1000);
        check("basic_valid_early", 32'(bus.instr_valid), 32'd0);
        next_cyc(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0050_0093;
        mid();
        check("wait_no_req", 32'(bus.mem_req), 32'd0);
        next_cyc(); bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        mid();
        check("basic_valid", 32'(bus.instr_valid), 32'd1);
        check("basic_instr", bus.instr, 32'h0050_0093);
        check("basic_instr_pc", bus.instr_pc, 32'h1000);
        check("basic_fault", 32'(bus.instr_fault), 32'd0);
        check("basic_no_pcen", 32'(bus.pc_enable), 32'd0);

        // backpressure
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            mid();
            check("bp_instr", bus.instr, 32'h0050_0093);
            check("bp_instr_pc", bus.instr_pc, 32'h1000);
            check("bp_no_req", 32'(bus.mem_req), 32'd0);
            check("bp_no_pcen", 32'(bus.pc_enable), 32'd0);
        end
        next_cyc(); bus.instr_ready = 1'b1;
        mid();
        check("bp_pcen", 32'(bus.pc_enable), 32'd1);
        next_cyc(); bus.instr_ready = 1'b0; bus.pc = 32'h1004;
        mid();
        check("post_hs_pcen", 32'(bus.pc_enable), 32'd0);
        check("post_hs_valid", 32'(bus.instr_valid), 32'd0);
        check("second_req", 32'(bus.mem_req), 32'd1);
        check("second_addr", bus.mem_addr, 32'h1004);

        // flush during WAIT, stale response arrives in DRAIN
        next_cyc(); bus.flush = 1'b1;
        mid();
        check("flush_wait_no_req", 32'(bus.mem_req), 32'd0);
        next_cyc(); bus.flush = 1'b0; bus.pc = 32'h2000;
        mid();
        check("drain_no_req", 32'(bus.mem_req), 32'd0);
        next_cyc(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        mid();
        check("stale_no_req", 32'(bus.mem_req), 32'd0);
        check("stale_not_valid", 32'(bus.instr_valid), 32'd0);
        next_cyc(); bus.mem_rvalid = 1'b0;
        mid();
        check("redirect_req", 32'(bus.mem_req), 32'd1);
        check("redirect_addr", bus.mem_addr, 32'h2000);
        check("redirect_not_valid", 32'(bus.instr_valid), 32'd0);
        next_cyc(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00A0_0113;
        mid();
        next_cyc(); bus.mem_rvalid = 1'b0; bus.instr_ready = 1'b1;
        mid();
        check("redirect_instr", bus.instr, 32'h00A0_0113);
        check("redirect_instr_pc", bus.instr_pc, 32'h2000);
        check("redirect_pcen", 32'(bus.pc_enable), 32'd1);

        // misaligned pc
        next_cyc(); bus.instr_ready = 1'b0; bus.pc = 32'h1002;
        mid();
        check("mis_no_req", 32'(bus.mem_req), 32'd0);
        next_cyc();
        mid();
        check("mis_valid", 32'(bus.instr_valid), 32'd1);
        check("mis_fault", 32'(bus.instr_fault), 32'd1);
        check("mis_instr", bus.instr, NOP);
        check("mis_instr_pc", bus.instr_pc, 32'h1002);
        check("mis_no_req_hold", 32'(bus.mem_req), 32'd0);

        // flush in HOLD beats instr_ready
        next_cyc(); bus.instr_ready = 1'b1; bus.flush = 1'b1;
        mid();
        check("hold_flush_no_pcen", 32'(bus.pc_enable), 32'd0);
        next_cyc(); bus.instr_ready = 1'b0; bus.flush = 1'b0; bus.pc = 32'h3000;
        mid();
        check("hold_flush_valid", 32'(bus.instr_valid), 32'd0);
        check("to_req", 32'(bus.mem_req), 32'd1);
        check("to_addr", bus.mem_addr, 32'h3000);

        // timeout: four silent WAIT cycles
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            mid();
            check("to_wait_no_req", 32'(bus.mem_req), 32'd0);
            check("to_wait_no_err", 32'(bus.fetch_err), 32'd0);
        end
        next_cyc();
        mid();
        check("to_err", 32'(bus.fetch_err), 32'd1);
        check("to_refetch_req", 32'(bus.mem_req), 32'd1);
        check("to_refetch_addr", bus.mem_addr, 32'h3000);
        next_cyc(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
        mid();
        next_cyc(); bus.mem_rvalid = 1'b0; bus.instr_ready = 1'b1;
        mid();
        check("to_instr", bus.instr, 32'h1111_2222);
        check("to_err_sticky", 32'(bus.fetch_err), 32'd1);
        check("to_pcen", 32'(bus.pc_enable), 32'd1);

        // asynchronous reset while holding a faulted instruction
        next_cyc(); bus.instr_ready = 1'b0; bus.pc = 32'h1006;
        mid();
        next_cyc();
        mid();
        check("ar_pre_valid", 32'(bus.instr_valid), 32'd1);
        check("ar_pre_fault", 32'(bus.instr_fault), 32'd1);
        check("ar_pre_err", 32'(bus.fetch_err), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.instr_valid), 32'd0);
        check("ar_fault", 32'(bus.instr_fault), 32'd0);
        check("ar_err", 32'(bus.fetch_err), 32'd0);
        bus.pc = 32'h1000;
        next_cyc();
        next_cyc(); reset_n = 1'b1;
        mid();
        check("ar_req", 32'(bus.mem_req), 32'd1);
        check("ar_addr", bus.mem_addr, 32'h1000);

        // randomized run against the reference model
        next_cyc(); reset_n = 1'b0;
        next_cyc(); reset_n = 1'b1; rand_phase = 1'b1;
        repeat (3000) @(posedge clk);
        #3 rand_phase = 1'b0;
        repeat (3) @(posedge clk);
        check("handshake_count_ok", 32'(handshakes >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current `pc`, issues one word read to instruction memory and captures the returned word.
- Presents the word to decode with a valid/ready handshake.
- Pulses `pc_enable` back to the PC so it advances only when decode has accepted an instruction.
- Supports a flush/redirect, a misaligned-PC fault and a memory-timeout watchdog.

Parameters:
- TIMEOUT, 16, max cycles to wait for `mem_rvalid` after a request before raising `fetch_err` (2..255).
- NOP_INSTR, 32'h00000013, word presented on `instr` when a faulted fetch is delivered.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- pc  input  32  current PC from program counter.
- pc_enable  output  1  advance-PC strobe to program counter.
- flush  input  1  redirect: abandon current fetch; PC is being reloaded externally this cycle.
- mem_req  output  1  single-cycle read request.
- mem_addr  output  32  read address.
- mem_rdata  input  32  read data.
- mem_rvalid  input  1  read data valid; at most one response per request, ≥1 cycle after `mem_req`.
- instr  output  32  fetched instruction.
- instr_pc  output  32  PC of `instr`.
- instr_valid  output  1  `instr`/`instr_pc` valid.
- instr_ready  input  1  decode accepts.
- instr_fault  output  1  qualifies `instr_valid`: misaligned PC, `NOP_INSTR` delivered.
- fetch_err  output  1  sticky timeout error.

Behaviour:
- **Reset** (reset_n low, async): state=REQ, instr=0, instr_pc=0, instr_valid=0, instr_fault=0, fetch_err=0, timeout counter=0, discard flag=0.
- **States:** REQ, WAIT, HOLD, DRAIN. Single outstanding memory request ever.
- **REQ:**
  - `mem_req = !flush && pc[1:0]==0`; `mem_addr = pc` (combinational).
  - If `mem_req`: -> WAIT, counter cleared.
  - If `pc[1:0]!=0` and `!flush`: capture instr=NOP_INSTR, instr_pc=pc, instr_fault=1, instr_valid=1; -> HOLD, no memory access.
  - If `flush`: stay in REQ.
- **WAIT:**
  - Counter increments each cycle.
  - On `mem_rvalid`: capture instr=mem_rdata, instr_pc=the address requested, instr_fault=0, instr_valid=1; -> HOLD.
  - If counter reaches TIMEOUT without `rvalid`: fetch_err=1 (sticky until reset), -> REQ (refetch same pc).
  - On `flush` (with or without `rvalid` same cycle): if `rvalid` also high, drop the data and -> REQ; else -> DRAIN.
- **DRAIN:**
  - Waits for the stale `mem_rvalid` and discards it, then -> REQ.
  - TIMEOUT counter also applies here: on expiry set fetch_err and -> REQ.
  - `flush` in DRAIN has no extra effect.
- **HOLD:**
  - `instr_valid=1`; instr, instr_pc and instr_fault held stable while `!instr_ready`.
  - Handshake = instr_valid && instr_ready. On handshake: instr_valid->0, -> REQ, and `pc_enable=1` that cycle.
  - The PC updates on the same edge, so the next REQ uses the new pc. Fetch-to-fetch minimum is 3 cycles: REQ, WAIT with `rvalid`, HOLD with ready.
  - `flush` in HOLD: instr_valid->0, -> REQ, no `pc_enable`, even if `instr_ready` is high.
- **`pc_enable`** = (state==HOLD) && instr_ready && !flush; combinational, never asserted in any other state.
- **`mem_rvalid` outside WAIT/DRAIN** is ignored.
- **Reset mid-WAIT:** returns to REQ with no discard. The memory is reset by the same `reset_n`, so no stale response exists.

Test Plan:
- **Basic fetch:** reset release with pc=0x1000; memory returns 0x00500093 one cycle after req → mem_req=1/mem_addr=0x1000 in cycle 1; instr=0x00500093, instr_pc=0x1000, instr_valid=1 in cycle 3; pc_enable=1 the cycle instr_ready=1.
- **Backpressure:** instr_ready low 5 cycles in HOLD → instr/instr_pc stable, no mem_req, pc_enable=0 throughout; single pc_enable pulse when ready rises.
- **Flush during WAIT:** flush 1 cycle after req to 0x1004, stale rvalid (0xDEADBEEF) 2 cycles later, pc reloaded to 0x2000 → DEADBEEF never valid; next mem_req addr=0x2000 only after the stale rvalid.
- **Misaligned:** pc=0x1002 → no mem_req; instr_valid=1, instr_fault=1, instr=0x00000013, instr_pc=0x1002.
- **Timeout:** TIMEOUT=4, memory silent → fetch_err=1 after 4 WAIT cycles, new mem_req to same pc; fetch_err stays 1 until reset_n low.
- **Async reset mid-HOLD:** reset_n low between edges → instr_valid, fetch_err, instr_fault drop immediately; after release, first mem_req at pc=0x1000.
